// File: rtl/int8_mul_pkg.sv
// Shared widths, types and the ripple-carry helper used by the 8x8 array multiplier.
package int8_mul_pkg;

    localparam int OPW   = 8;
    localparam int PRODW = 16;

    typedef logic [OPW-1:0]   operand_t;
    typedef logic [PRODW-1:0] product_t;

    // One adder row: a bit-serial carry chain across the full product width.
    function automatic product_t rca_add(input product_t x, input product_t z);
        product_t s;
        logic     c;
        s = '0;
        c = 1'b0;
        for (int k = 0; k < PRODW; k++) begin
            s[k] = x[k] ^ z[k] ^ c;
            c    = (x[k] & z[k]) | (c & (x[k] ^ z[k]));
        end
        return s;
    endfunction

endpackage

// File: rtl/int8_mul_array.sv
// Purely combinational unsigned 8x8 array multiplier: AND plane plus seven ripple-carry rows.
module int8_mul_array
    import int8_mul_pkg::*;
(
    input  operand_t a_i,
    input  operand_t b_i,
    output product_t p_o
);

    // Partial product i is a gated by b[i], shifted left by i, folded into the running sum.
    always_comb begin
        product_t acc_s;
        product_t pp_s;
        acc_s = {8'h00, a_i & {OPW{b_i[0]}}};
        pp_s  = '0;
        for (int i = 1; i < OPW; i++) begin
            pp_s  = {8'h00, a_i & {OPW{b_i[i]}}} << i;
            acc_s = rca_add(acc_s, pp_s);
        end
        p_o = acc_s;
    end

endmodule

// File: rtl/int8_multiplier.sv
// Unsigned 8x8 multiplier: combinational low byte/overflow plus a one-cycle registered capture path.
module int8_multiplier
    import int8_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    a,
    input  logic [OPW-1:0]    b,
    output logic [OPW-1:0]    y,
    output logic              ovf,
    input  logic              in_valid,
    output logic [PRODW-1:0]  p_q,
    output logic              ovf_q,
    output logic              out_valid
);

    product_t   prod_s;
    product_t   p_d;
    logic       ovf_d;
    logic       valid_d;

    int8_mul_array u_array (
        .a_i (a),
        .b_i (b),
        .p_o (prod_s)
    );

    assign y   = prod_s[OPW-1:0];
    assign ovf = |prod_s[PRODW-1:OPW];

    // Capture on request; otherwise hold the product and drop the valid pulse.
    always_comb begin
        p_d     = p_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        if (in_valid) begin
            p_d     = prod_s;
            ovf_d   = ovf;
            valid_d = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q       <= 16'h0000;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            p_q       <= p_d;
            ovf_q     <= ovf_d;
            out_valid <= valid_d;
        end
    end

endmodule

// File: tb/tb_int8_multiplier.sv
// Directed plus exhaustive bench for int8_multiplier with a scoreboard for the registered path.
module tb_int8_multiplier;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  y;
    logic        ovf;
    logic        in_valid;
    logic [15:0] p_q;
    logic        ovf_q;
    logic        out_valid;

    int checks;
    int errors;

    logic [16:0] exp_q[$];
    logic [15:0] last_p;
    logic        last_ovf;

    int8_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .y         (y),
        .ovf       (ovf),
        .in_valid  (in_valid),
        .p_q       (p_q),
        .ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic comb_chk(input logic [7:0] av, input logic [7:0] bv);
        int unsigned p;
        a = av;
        b = bv;
        #1;
        p = av * bv;
        chk("y", {8'h00, y}, 16'(p % 256));
        chk("ovf", {15'h0000, ovf}, {15'h0000, (p > 255) ? 1'b1 : 1'b0});
    endtask

    // Drive one cycle of stimulus, then check the registered outputs 1 unit after the edge.
    task automatic drive(input logic [7:0] av, input logic [7:0] bv, input logic v);
        int unsigned p;
        logic [16:0] e;
        a        = av;
        b        = bv;
        in_valid = v;
        if (v) begin
            p = av * bv;
            exp_q.push_back({(p > 255) ? 1'b1 : 1'b0, p[15:0]});
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_valid", {15'h0000, out_valid}, 16'h0001);
            chk("p_q", p_q, e[15:0]);
            chk("ovf_q", {15'h0000, ovf_q}, {15'h0000, e[16]});
            last_p   = e[15:0];
            last_ovf = e[16];
        end else begin
            chk("out_valid_idle", {15'h0000, out_valid}, 16'h0000);
            chk("p_q_hold", p_q, last_p);
            chk("ovf_q_hold", {15'h0000, ovf_q}, {15'h0000, last_ovf});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        last_p   = 16'h0000;
        last_ovf = 1'b0;
        rst_n    = 1'b0;
        a        = 8'd0;
        b        = 8'd0;
        in_valid = 1'b0;
        #1;
        chk("rst_p_q", p_q, 16'h0000);
        chk("rst_ovf_q", {15'h0000, ovf_q}, 16'h0000);
        chk("rst_out_valid", {15'h0000, out_valid}, 16'h0000);
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(8'd200, 8'd3, 1'b1);
        drive(8'd0, 8'd0, 1'b0);
        drive(8'd2, 8'd3, 1'b1);
        drive(8'd7, 8'd9, 1'b1);
        drive(8'd255, 8'd1, 1'b1);
        drive(8'd0, 8'd0, 1'b0);

        // Mid-run reset with a capture pending, then first capture after release.
        drive(8'd50, 8'd50, 1'b1);
        a        = 8'd9;
        b        = 8'd9;
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_p_q", p_q, 16'h0000);
        chk("midrst_ovf_q", {15'h0000, ovf_q}, 16'h0000);
        chk("midrst_out_valid", {15'h0000, out_valid}, 16'h0000);
        chk("midrst_y", {8'h00, y}, 16'd81);
        @(posedge clk);
        #1;
        chk("inrst_p_q", p_q, 16'h0000);
        chk("inrst_out_valid", {15'h0000, out_valid}, 16'h0000);
        #3;
        rst_n = 1'b1;
        exp_q.delete();
        last_p   = 16'h0000;
        last_ovf = 1'b0;
        drive(8'd3, 8'd4, 1'b1);
        drive(8'd0, 8'd0, 1'b0);

        comb_chk(8'd5, 8'd1);
        comb_chk(8'd5, 8'd2);
        comb_chk(8'd5, 8'd5);
        comb_chk(8'd5, 8'd0);
        comb_chk(8'd0, 8'd5);
        comb_chk(8'd1, 8'd5);
        comb_chk(8'd16, 8'd16);
        comb_chk(8'd255, 8'd255);
        comb_chk(8'd15, 8'd17);

        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                comb_chk(8'(ai), 8'(bi));
            end
        end

        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/int8_multiplier.md
Name: int8_multiplier

Overview:
- Unsigned 8x8 integer multiplier for datapath arithmetic.
- Combinational result port y gives the low byte of a*b and is valid within the same time step as the inputs.
- A registered side path captures the full 16-bit product and an overflow flag on request, for clocked consumers.
- The block sits between operand registers and an accumulator/writeback stage.

Parameters:
- none. Operand width is fixed at 8 bits; product width is fixed at 16 bits.

Ports:
- clk  in  1  single clock; all registers are rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- a  in  8  operand A, unsigned.
- b  in  8  operand B, unsigned.
- y  out  8  combinational product (a*b) mod 256.
- ovf  out  1  combinational; 1 when a*b > 255.
- in_valid  in  1  capture request for the registered path.
- p_q  out  16  registered full product.
- ovf_q  out  1  registered overflow flag.
- out_valid  out  1  registered valid for p_q and ovf_q.

Behaviour:
- All arithmetic is unsigned, with no sign extension.
- Combinational path:
  - y = low 8 bits of a*b, with no clock dependency.
  - y must settle within one simulation time unit of an a/b change.
  - No registers sit between a/b and y or ovf.
  - ovf = OR of product bits [15:8].
- Registered path, latency 1 cycle:
  - On a rising clk edge with in_valid=1: p_q <= a*b (16 bits), ovf_q <= ovf, out_valid <= 1.
  - On a rising clk edge with in_valid=0: out_valid <= 0, and p_q and ovf_q hold their values.
  - out_valid is therefore a one-cycle pulse per request.
  - Back-to-back requests give back-to-back results; there is no backpressure.
- Reset:
  - While rst_n=0: p_q=0, ovf_q=0, out_valid=0, immediately and independent of clk.
  - Reset asserted mid-operation discards the pending capture.
  - The first capture occurs at the first rising edge with rst_n=1 and in_valid=1.
  - y and ovf are unaffected by reset and keep following a and b.
- Boundaries:
  - a=0 or b=0 gives 0 with ovf=0.
  - Operand 1 returns the other operand unchanged.
  - 255*255 = 65025 (0xFE01): y=0x01, ovf=1.
  - 16*16 = 256: y=0x00, ovf=1.
  - X or Z on inputs need not be resolved.
- Implementation:
  - Structural array multiplier: 8 partial-product rows (a AND b[i], shifted by i).
  - Partial products are summed by 7 ripple-carry adder rows.
  - The behavioural `*` operator is not used in the datapath.

Decomposition:
- Shared package int8_mul_pkg holds:
  - OPW=8 and PRODW=16 constants;
  - typedefs operand_t (8-bit) and product_t (16-bit).
- One natural sub-module, int8_mul_array: the purely combinational 8x8 to 16-bit array (AND plane plus adder rows).
- The top level instantiates int8_mul_array, derives y and ovf from it, and holds the output registers.

Test Plan:
- Assert rst_n=0 mid-run with in_valid=1 -> p_q=0, ovf_q=0, out_valid=0 immediately. After release, the next edge with a=3, b=4, in_valid=1 -> p_q=12.
- Combinational checks, each sampled 1 time unit after the input change:
  - a=5, b=1 -> y=5.
  - a=5, b=2 -> y=10.
  - a=5, b=5 -> y=25.
  - a=5, b=0 -> y=0.
  - a=0, b=5 -> y=0.
  - a=1, b=5 -> y=5.
  - ovf=0 for all of the above.
- Overflow:
  - a=16, b=16 -> y=0x00, ovf=1.
  - a=255, b=255 -> y=0x01, ovf=1.
  - a=15, b=17 -> y=255, ovf=0.
- Registered path: in_valid pulsed for one cycle with a=200, b=3 -> one cycle later p_q=600, ovf_q=1, out_valid=1. The following cycle out_valid=0 and p_q holds 600.
- Back-to-back: in_valid=1 for 3 cycles with (2,3), (7,9), (255,1) -> p_q = 6, 63, 255 on consecutive cycles, with out_valid held at 1.
- Exhaustive sweep: all 65536 (a,b) pairs -> y equals (a*b) mod 256 and ovf equals (a*b > 255).
